// File: rtl/alu_issue.sv
// alu_issue: in-order issue sequencer in front of the CPU ALU.
// Buffers 16-bit reg-reg instruction words in a small FIFO. Reads operands
// from a 16x16 register file and drives the ALU operands. Waits out the ALU
// latency, then writes the result back with a one-cycle writeback pulse.
//
// Ports:
//   clk, resetn             clock; asynchronous reset, asserted high
//   in_valid/in_ready       instruction handshake; in_instr = {op, rd, rs, rt}
//   ld_valid/ld_addr/ld_data direct register-file write
//   alu_ctrl/alu_a/alu_b    registered ALU operands; alu_y is the ALU result
//   wb_valid/wb_addr/wb_data one-cycle writeback pulse
//   busy                    sequencer active or FIFO non-empty
//   dbg_addr/dbg_data       combinational register-file read

package alu_issue_pkg;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] ALU_OP_SUB = 4'h1;
    localparam logic [OP_W-1:0] ALU_OP_AND = 4'h2;
    localparam logic [OP_W-1:0] ALU_OP_OR  = 4'h3;
    localparam logic [OP_W-1:0] ALU_OP_XOR = 4'h4;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } instr_t;
endpackage

module alu_issue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [15:0]                        in_instr,
    input  logic                               ld_valid,
    input  logic [alu_issue_pkg::REG_AW-1:0]   ld_addr,
    input  logic [alu_issue_pkg::DATA_W-1:0]   ld_data,
    output logic [alu_issue_pkg::OP_W-1:0]     alu_ctrl,
    output logic [alu_issue_pkg::DATA_W-1:0]   alu_a,
    output logic [alu_issue_pkg::DATA_W-1:0]   alu_b,
    input  logic [alu_issue_pkg::DATA_W-1:0]   alu_y,
    output logic                               wb_valid,
    output logic [alu_issue_pkg::REG_AW-1:0]   wb_addr,
    output logic [alu_issue_pkg::DATA_W-1:0]   wb_data,
    output logic                               busy,
    input  logic [alu_issue_pkg::REG_AW-1:0]   dbg_addr,
    output logic [alu_issue_pkg::DATA_W-1:0]   dbg_data
);
    import alu_issue_pkg::*;

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W  = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
    localparam int unsigned NREGS  = 1 << REG_AW;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                pop;
    logic                capture;
    logic                cnt_dec;
    logic                push;

    logic [15:0]         fifo_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt;
    instr_t              head;

    logic [DATA_W-1:0]   rf [NREGS];
    logic [REG_AW-1:0]   rd_q;
    logic [LAT_W-1:0]    cnt;

    // Ready is a pure function of occupancy: no push while full, even on a pop.
    assign in_ready = (fifo_cnt < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = instr_t'(fifo_mem[rd_ptr]);
    assign busy     = (state != ST_IDLE) || (fifo_cnt != '0);
    assign dbg_data = rf[dbg_addr];

    // FSM state register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and control strobes
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_cnt != '0) begin
                    pop       = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = ST_WB;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WB: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FIFO storage; contents are meaningless once pointers are reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_instr;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Issue operands, latency counter and writeback outputs
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            alu_ctrl <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            rd_q     <= '0;
            cnt      <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= capture;
            if (pop) begin
                alu_ctrl <= head.op;
                alu_a    <= rf[head.rs];
                alu_b    <= rf[head.rt];
                rd_q     <= head.rd;
                cnt      <= LAT_W'(ALU_LAT);
            end else if (cnt_dec) begin
                cnt <= cnt - LAT_W'(1);
            end
            if (capture) begin
                wb_addr <= rd_q;
                wb_data <= alu_y;
            end
        end
    end

    // Register file; r0 is never written. Writeback is last so it wins a collision.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (ld_valid && (ld_addr != '0)) begin
                rf[ld_addr] <= ld_data;
            end
            if (capture && (rd_q != '0)) begin
                rf[rd_q] <= alu_y;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: stimulus pushes expected writebacks (with
// the operands issued for them) into a queue; a monitor compares on each
// wb_valid pulse. A behavioural one-stage ALU closes the loop.

module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        ld_valid;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_y;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        busy;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        logic [3:0]  ctrl;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  addr;
        logic [15:0] data;
        int          gap;
    } exp_t;

    exp_t sb[$];

    alu_issue #(.DEPTH(4), .ALU_LAT(1)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .alu_ctrl (alu_ctrl),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .busy     (busy),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // One register stage of ALU
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            alu_y <= '0;
        end else begin
            case (alu_ctrl)
                ALU_OP_ADD: alu_y <= alu_a + alu_b;
                ALU_OP_SUB: alu_y <= alu_a - alu_b;
                ALU_OP_AND: alu_y <= alu_a & alu_b;
                ALU_OP_OR:  alu_y <= alu_a | alu_b;
                ALU_OP_XOR: alu_y <= alu_a ^ alu_b;
                default:    alu_y <= '0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every writeback pulse must match the head of the scoreboard
    logic wb_prev = 1'b0;
    int   last_wb = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (wb_valid) begin
            check("wb_single_cycle", 32'(wb_prev), 32'd0);
            check("wb_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wb_addr",    32'(wb_addr),  32'(e.addr));
                check("wb_data",    32'(wb_data),  32'(e.data));
                check("issue_ctrl", 32'(alu_ctrl), 32'(e.ctrl));
                check("issue_a",    32'(alu_a),    32'(e.a));
                check("issue_b",    32'(alu_b),    32'(e.b));
                if (e.gap != 0) check("wb_gap", 32'(cyc - last_wb), 32'(e.gap));
            end
            last_wb = cyc;
        end
        wb_prev = wb_valid;
    end

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt);
        return {op, rd, rs, rt};
    endfunction

    task automatic expect_wb(input logic [3:0] ctrl, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] addr, input logic [15:0] data, input int gap);
        exp_t e;
        e.ctrl = ctrl; e.a = a; e.b = b; e.addr = addr; e.data = data; e.gap = gap;
        sb.push_back(e);
    endtask

    // All tasks start and end just after a falling edge
    task automatic ld(input logic [3:0] addr, input logic [15:0] data);
        ld_valid = 1'b1; ld_addr = addr; ld_data = data;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic push_one(input logic [15:0] instr);
        check("push_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_instr = instr;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (busy || wb_valid); i++) @(negedge clk);
        check("idle_timeout", 32'(busy || wb_valid), 32'd0);
    endtask

    task automatic check_rf(input string name, input logic [3:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        check(name, 32'(dbg_data), 32'(exp));
    endtask

    logic [15:0] words [7];
    logic [15:0] rwords [3];

    initial begin : stim
        int  n_acc;
        bit  saw_full;
        bit  acc;

        resetn = 1'b1; in_valid = 1'b0; in_instr = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst_alu_a",    32'(alu_a),    32'd0);
        check("rst_alu_b",    32'(alu_b),    32'd0);
        check("rst_wb_addr",  32'(wb_addr),  32'd0);
        check("rst_wb_data",  32'(wb_data),  32'd0);
        resetn = 1'b0;
        @(negedge clk);

        // Basic ADD with exact latency: push at P, pop at P+1, pulse after P+3
        ld(4'd1, 16'h0003);
        ld(4'd2, 16'h0004);
        check_rf("ld_r1", 4'd1, 16'h0003);
        expect_wb(ALU_OP_ADD, 16'h0003, 16'h0004, 4'd3, 16'h0007, 0);
        push_one(mk(ALU_OP_ADD, 4'd3, 4'd1, 4'd2));
        check("lat_p0", 32'(wb_valid), 32'd0);
        @(negedge clk);
        check("lat_p1", 32'(wb_valid), 32'd0);
        check("issue_a_p1", 32'(alu_a), 32'h3);
        check("issue_b_p1", 32'(alu_b), 32'h4);
        check("issue_ctrl_p1", 32'(alu_ctrl), 32'(ALU_OP_ADD));
        @(negedge clk);
        check("lat_p2", 32'(wb_valid), 32'd0);
        @(negedge clk);
        check("lat_p3", 32'(wb_valid), 32'd1);
        wait_idle();
        check_rf("add_r3", 4'd3, 16'h0007);

        // Dependent pair, back to back
        expect_wb(ALU_OP_ADD, 16'h0003, 16'h0004, 4'd3, 16'h0007, 0);
        expect_wb(ALU_OP_SUB, 16'h0007, 16'h0003, 4'd4, 16'h0004, 4);
        in_valid = 1'b1; in_instr = mk(ALU_OP_ADD, 4'd3, 4'd1, 4'd2);
        @(negedge clk);
        in_instr = mk(ALU_OP_SUB, 4'd4, 4'd3, 4'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();
        check_rf("dep_r4", 4'd4, 16'h0004);

        // Seven words pushed continuously through a 4-deep FIFO
        words[0] = mk(ALU_OP_XOR, 4'd5,  4'd1,  4'd2);
        words[1] = mk(ALU_OP_OR,  4'd6,  4'd3,  4'd4);
        words[2] = mk(ALU_OP_AND, 4'd7,  4'd3,  4'd2);
        words[3] = mk(ALU_OP_SUB, 4'd8,  4'd1,  4'd2);
        words[4] = mk(ALU_OP_ADD, 4'd9,  4'd8,  4'd1);
        words[5] = mk(ALU_OP_XOR, 4'd10, 4'd8,  4'd7);
        words[6] = mk(ALU_OP_SUB, 4'd11, 4'd10, 4'd9);
        expect_wb(ALU_OP_XOR, 16'h0003, 16'h0004, 4'd5,  16'h0007, 0);
        expect_wb(ALU_OP_OR,  16'h0007, 16'h0004, 4'd6,  16'h0007, 4);
        expect_wb(ALU_OP_AND, 16'h0007, 16'h0004, 4'd7,  16'h0004, 4);
        expect_wb(ALU_OP_SUB, 16'h0003, 16'h0004, 4'd8,  16'hFFFF, 4);
        expect_wb(ALU_OP_ADD, 16'hFFFF, 16'h0003, 4'd9,  16'h0002, 4);
        expect_wb(ALU_OP_XOR, 16'hFFFF, 16'h0004, 4'd10, 16'hFFFB, 4);
        expect_wb(ALU_OP_SUB, 16'hFFFB, 16'h0002, 4'd11, 16'hFFF9, 4);
        n_acc = 0; saw_full = 1'b0;
        for (int t = 0; t < 200 && n_acc < 7; t++) begin
            in_valid = 1'b1;
            in_instr = words[n_acc];
            acc = in_ready;
            if (!in_ready) saw_full = 1'b1;
            @(negedge clk);
            if (acc) n_acc++;
        end
        in_valid = 1'b0;
        check("full_all_pushed", 32'(n_acc), 32'd7);
        check("full_saw_not_ready", 32'(saw_full), 32'd1);
        wait_idle();
        check("full_sb_drained", 32'(sb.size()), 32'd0);
        check_rf("full_r11", 4'd11, 16'hFFF9);
        check_rf("full_r8",  4'd8,  16'hFFFF);

        // r0 stays zero; writeback pulse still carries the ALU value
        ld(4'd0, 16'hFFFF);
        check_rf("r0_after_ld", 4'd0, 16'h0000);
        expect_wb(ALU_OP_ADD, 16'h0003, 16'h0004, 4'd0, 16'h0007, 0);
        push_one(mk(ALU_OP_ADD, 4'd0, 4'd1, 4'd2));
        wait_idle();
        check_rf("r0_after_wb", 4'd0, 16'h0000);

        // Load on the capture edge loses to the writeback
        ld(4'd3, 16'h0000);
        check_rf("coll_pre_r3", 4'd3, 16'h0000);
        expect_wb(ALU_OP_ADD, 16'h0003, 16'h0004, 4'd3, 16'h0007, 0);
        push_one(mk(ALU_OP_ADD, 4'd3, 4'd1, 4'd2));
        @(negedge clk);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 16'h1234;
        @(negedge clk);
        ld_valid = 1'b0;
        check("coll_wb_edge", 32'(wb_valid), 32'd1);
        wait_idle();
        check_rf("coll_r3", 4'd3, 16'h0007);

        // Reset mid-EXEC with two entries still queued
        rwords[0] = mk(ALU_OP_ADD, 4'd12, 4'd1, 4'd2);
        rwords[1] = mk(ALU_OP_SUB, 4'd13, 4'd1, 4'd2);
        rwords[2] = mk(ALU_OP_OR,  4'd14, 4'd1, 4'd2);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_instr = rwords[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("rst_pre_busy", 32'(busy), 32'd1);
        check("rst_pre_wb", 32'(wb_valid), 32'd0);
        resetn = 1'b1;
        #1;
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_busy",     32'(busy),     32'd0);
        check("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_mid_alu_a",    32'(alu_a),    32'd0);
        check("rst_mid_alu_ctrl", 32'(alu_ctrl), 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_post_busy", 32'(busy), 32'd0);
        for (int r = 0; r < 16; r++) begin
            check_rf("rst_rf_zero", 4'(r), 16'h0000);
        end
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Sequencer sitting in front of the CPU `alu`, producing the `ctrl`/`a`/`b` operands the ALU consumes and collecting its result `y`. It accepts 16-bit register-register instruction words over a valid/ready handshake and buffers them in a small FIFO. It reads operands from an internal 16x16 register file, drives the ALU, waits out the ALU latency, and writes the result back with a one-cycle writeback pulse.

## Interface
- `DEPTH`, 4: instruction FIFO entries (power of two, >=2).
- `ALU_LAT`, 1: ALU register stages between `alu_ctrl`/`alu_a`/`alu_b` and `alu_y`.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous reset, active-high. The reset is `resetn`, asynchronous, active-high; the clock is `clk`.
- `in_valid` in 1: instruction word valid.
- `in_ready` out 1: FIFO can accept; high when count < `DEPTH`.
- `in_instr` in 16: fields are [15:12] ALU op (ALU_OP_* encoding), [11:8] rd, [7:4] rs, [3:0] rt.
- `ld_valid` in 1: direct register-file write strobe.
- `ld_addr` in 4, `ld_data` in 16: direct write address and data.
- `alu_ctrl` out 4, `alu_a` out 16, `alu_b` out 16: registered ALU operands.
- `alu_y` in 16: ALU result.
- `wb_valid` out 1: one-cycle writeback pulse.
- `wb_addr` out 4, `wb_data` out 16: writeback destination and value.
- `busy` out 1: FSM not IDLE or FIFO non-empty.
- `dbg_addr` in 4, `dbg_data` out 16: combinational register-file read.

## Operation
- FIFO behaviour:
  - Push on `in_valid && in_ready`. Pop is issued by the FSM only.
  - `in_ready` depends on count only, so there is no push when full, even in a cycle that also pops.
  - Order is strictly preserved.
- FSM states: IDLE, EXEC, WB.
  - IDLE: if the FIFO is non-empty at an edge, pop the head, then:
    - register `alu_ctrl`=op, `alu_a`=rf[rs], `alu_b`=rf[rt];
    - latch rd;
    - set cnt=`ALU_LAT`;
    - go to EXEC.
  - EXEC: if cnt≠0, decrement cnt. If cnt==0, capture `alu_y`, then:
    - rf[rd]<=`alu_y`;
    - `wb_addr`<=rd, `wb_data`<=`alu_y`, `wb_valid`<=1;
    - go to WB.
  - WB: `wb_valid` is high for exactly this one cycle. Go to IDLE at the next edge.
- `alu_ctrl`/`alu_a`/`alu_b` hold their last issued values until the next pop.
- Register r0:
  - reads as 0x0000;
  - writes to r0 from WB or ld are discarded;
  - the `wb_*` pulse still occurs with the ALU value.
- Load port (`ld_valid`):
  - writes rf[`ld_addr`] at the edge in any state.
  - If it coincides with a writeback capture to the same address, the writeback wins.
- Operand reads see every rf write committed at earlier edges. Back-to-back dependent instructions need no stall, because issue is serialized.
- Arithmetic is done entirely by the ALU. This block passes 16-bit values through unmodified.

## Timing
- Reset values:
  - `in_ready`=1 (FIFO emptied);
  - `alu_ctrl`=0, `alu_a`=0, `alu_b`=0;
  - `wb_valid`=0, `wb_addr`=0, `wb_data`=0;
  - `busy`=0;
  - all rf=0, FSM=IDLE, cnt=0.
- Pop at edge E0 → operands valid after E0 → capture at edge E0+`ALU_LAT`+1 → `wb_valid` high during cycle [E0+`ALU_LAT`+1, E0+`ALU_LAT`+2).
- Push at edge P into an empty, idle block → pop at P+1.
- Throughput: one instruction per `ALU_LAT`+3 cycles.
- Reset asserted mid-EXEC or mid-WB:
  - in-flight instruction is dropped and produces no `wb_valid`;
  - FIFO contents are lost;
  - outputs return to reset values immediately (asynchronous).
- `dbg_data` reflects rf the same cycle, with no bypass of an in-progress capture.

## Test plan
- Reset, ld r1=0x0003 and r2=0x0004, then push ADD r3,r1,r2 → `alu_a`=3, `alu_b`=4, `alu_ctrl`=ALU_OP_ADD. `wb_valid` pulses with `wb_addr`=3, `wb_data`=0x0007 at pop+2 edges (`ALU_LAT`=1). `dbg_data`(3)=0x0007.
- Dependency: push ADD r3,r1,r2 then SUB r4,r3,r1 back-to-back → second issue sees `alu_a`=0x0007, writeback r4=0x0004. Pulses are exactly 4 cycles apart.
- Full FIFO: push 7 words continuously with `in_valid`=1 → `in_ready` drops once count=4. All 7 writebacks appear in push order, none lost or duplicated.
- r0: ld r0=0xFFFF, then ADD r0,r1,r2 → `wb_addr`=0, `wb_data`=0x0007 pulse, while `dbg_data`(0) stays 0x0000.
- Collision: ld r3=0x1234 on the same edge as the ADD r3 capture → r3=0x0007.
- Reset during EXEC with 2 entries queued → `wb_valid` never pulses, `in_ready`=1, `busy`=0, rf all 0x0000.
